crop_ctrl: RTL and testbench
============================

CROP_CTRL -- requirements
Module: crop_ctrl

Interface
REQ-001 Parameter PIXEL_BIT_WIDTH, default 12, pixel width of the controlled crop datapath (informational, no storage).
REQ-002 Parameter IN_ROWS, default 40, input frame height in beats.
REQ-003 Parameter IN_COLS, default 40, input frame width in beats.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid, out_ready  input  1 each  pixel handshake of the crop datapath; beat = in_valid && out_ready.
REQ-007 cfg_valid  input  1; cfg_ready  output  1; cfg_x1, cfg_w  input  CW=$clog2(IN_COLS+1); cfg_y1, cfg_h  input  RW=$clog2(IN_ROWS+1); config write handshake.
REQ-008 run  input  1  level: 1 = crop frames continuously, 0 = stop at next frame boundary.
REQ-009 win_x1, win_w  output  CW; win_y1, win_h  output  RW  active window driven to the crop datapath.
REQ-010 crop_en  output  1  datapath may emit pixels; in_window  output  1  current beat lies inside active window.
REQ-011 frame_done  output  1  one-cycle pulse; cfg_err  output  1  one-cycle pulse; busy  output  1  state != IDLE.

Function
REQ-012 Config accepted on cycle where cfg_valid && cfg_ready; accepted values checked: w>=1, h>=1, x1+w<=IN_COLS, y1+h<=IN_ROWS, sums evaluated one bit wider than operands.
REQ-013 Invalid config: discarded, cfg_err pulses the following cycle, no state change.
REQ-014 Valid config stored in one-deep pending shadow; cfg_ready = !pending_full.
REQ-015 Position counters x (0..IN_COLS-1), y (0..IN_ROWS-1) advance only on beat; x wraps to 0 and increments y; y wraps to 0 after IN_ROWS-1; last beat = x==IN_COLS-1 && y==IN_ROWS-1.
REQ-016 in_window combinational: y>=win_y1 && y<win_y1+win_h && x>=win_x1 && x<win_x1+win_w && crop_en.
REQ-017 FSM states IDLE, ARMED, ACTIVE, DRAIN.
REQ-018 IDLE: crop_en=0; counters still track beats; pending_full && run -> ARMED.
REQ-019 ARMED: crop_en=0; on last beat copy pending into win_*, clear pending, -> ACTIVE (first cropped frame starts at next beat, x=y=0).
REQ-020 ACTIVE: crop_en=1; on last beat frame_done pulses next cycle; if pending_full, win_* <= pending and pending cleared on the same edge; if run==0 -> DRAIN instead of staying.
REQ-021 Deassertion of run in ACTIVE takes effect only at frame boundary; DRAIN: crop_en=0, -> IDLE next cycle.
REQ-022 win_* never change except on a last-beat edge; mid-frame config writes only fill pending.
REQ-023 Config accept and last beat in same cycle: last beat consumes old pending first, new config lands in pending (cfg_ready was 1 only if pending empty, so applies next frame).
REQ-024 run rising while in ARMED with no beats: no action until last beat; run=0 in ARMED -> IDLE with pending retained.
REQ-025 Beats arriving in IDLE/ARMED keep counters aligned to the camera frame; no beat is counted twice or skipped.

Reset
REQ-026 On reset: state IDLE, x=y=0, pending empty, cfg_ready=1, win_x1=win_y1=0, win_w=IN_COLS, win_h=IN_ROWS, crop_en=0, in_window=0, frame_done=0, cfg_err=0, busy=0.
REQ-027 Reset asserted mid-frame aborts immediately; the next frame is assumed to start at the first beat after reset release.

Structure
REQ-028 Package crop_pkg holds state encoding (IDLE, ARMED, ACTIVE, DRAIN), CW/RW width functions and the window record (x1, y1, w, h).
REQ-029 Sub-module crop_pos_counter implements REQ-015 and outputs x, y, last_beat; crop_ctrl instantiates it once.

Verification
REQ-030 IN 40x40, write (x1=10,y1=10,w=20,h=20), run=1, stream 2 frames continuous beats -> crop_en rises after beat 1600, 400 in_window beats in frame 2, frame_done at end of frame 2.
REQ-031 Write (x1=30,w=11) -> cfg_err pulse, cfg_ready stays 1, win_* unchanged.
REQ-032 In ACTIVE write new window at beat 800 -> cfg_ready drops, win_* switch exactly on last-beat edge, cfg_ready returns 1 next cycle.
REQ-033 Drop run at beat 100 of an active frame -> crop_en stays 1 until last beat, DRAIN one cycle, IDLE, busy=0.
REQ-034 Random in_valid/out_ready stalls (50%) over 3 frames -> in_window count 400 per active frame, counters match reference model.
REQ-035 Assert reset at beat 500 of ACTIVE -> all outputs at REQ-026 values asynchronously, pending cleared.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared types for the crop controller: FSM states, window record and
// port-width helpers derived from the frame geometry.
package crop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ACTIVE,
    ST_DRAIN
  } crop_state_e;

  localparam int unsigned WIN_FW = 16;

  typedef struct packed {
    logic [WIN_FW-1:0] x1;
    logic [WIN_FW-1:0] y1;
    logic [WIN_FW-1:0] w;
    logic [WIN_FW-1:0] h;
  } crop_win_t;

  function automatic int unsigned col_w(input int unsigned cols);
    return $clog2(cols + 1);
  endfunction

  function automatic int unsigned row_w(input int unsigned rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/crop_pos_counter.sv
// Raster position tracker: x/y advance on every accepted beat and wrap at
// the frame edges; last_beat_o flags the final beat of a frame.
module crop_pos_counter
  import crop_pkg::*;
#(
  parameter int unsigned IN_ROWS = 40,
  parameter int unsigned IN_COLS = 40,
  parameter int unsigned CW      = col_w(IN_COLS),
  parameter int unsigned RW      = row_w(IN_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          beat_i,
  output logic [CW-1:0] x_o,
  output logic [RW-1:0] y_o,
  output logic          last_beat_o
);

  logic [CW-1:0] x_q, x_d;
  logic [RW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == CW'(IN_COLS - 1));
  assign y_end = (y_q == RW'(IN_ROWS - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (beat_i) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + RW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign last_beat_o = beat_i && x_end && y_end;

endmodule

// File: rtl/crop_ctrl.sv
// Crop window controller: validates and double-buffers window configs,
// arms on run and swaps the active window only at frame boundaries.
module crop_ctrl
  import crop_pkg::*;
#(
  parameter  int unsigned PIXEL_BIT_WIDTH = 12,
  parameter  int unsigned IN_ROWS         = 40,
  parameter  int unsigned IN_COLS         = 40,
  localparam int unsigned CW              = col_w(IN_COLS),
  localparam int unsigned RW              = row_w(IN_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          out_ready,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_x1,
  input  logic [CW-1:0] cfg_w,
  input  logic [RW-1:0] cfg_y1,
  input  logic [RW-1:0] cfg_h,
  input  logic          run,
  output logic [CW-1:0] win_x1,
  output logic [CW-1:0] win_w,
  output logic [RW-1:0] win_y1,
  output logic [RW-1:0] win_h,
  output logic          crop_en,
  output logic          in_window,
  output logic          frame_done,
  output logic          cfg_err,
  output logic          busy
);

  if (PIXEL_BIT_WIDTH < 1 || IN_COLS < 2 || IN_ROWS < 2 || CW > WIN_FW || RW > WIN_FW)
  begin : g_bad_params
    $error("crop_ctrl: unsupported parameter set");
  end

  crop_state_e state_q, state_d;
  crop_win_t   win_q, win_d, pend_q, pend_d, cfg_win;
  logic        pend_full_q, pend_full_d;
  logic        frame_done_q, frame_done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        win_load;

  logic          beat, last_beat;
  logic [CW-1:0] pos_x;
  logic [RW-1:0] pos_y;
  logic          cfg_acc, cfg_ok;

  assign beat = in_valid && out_ready;

  crop_pos_counter #(
    .IN_ROWS(IN_ROWS),
    .IN_COLS(IN_COLS),
    .CW     (CW),
    .RW     (RW)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .beat_i     (beat),
    .x_o        (pos_x),
    .y_o        (pos_y),
    .last_beat_o(last_beat)
  );

  // Bounds sums carry one extra bit so x1+w cannot wrap past the frame edge.
  assign cfg_ok = (cfg_w != '0) && (cfg_h != '0)
               && (({1'b0, cfg_x1} + {1'b0, cfg_w}) <= (CW+1)'(IN_COLS))
               && (({1'b0, cfg_y1} + {1'b0, cfg_h}) <= (RW+1)'(IN_ROWS));
  assign cfg_acc = cfg_valid && cfg_ready;
  assign cfg_win = '{x1: WIN_FW'(cfg_x1), y1: WIN_FW'(cfg_y1),
                     w:  WIN_FW'(cfg_w),  h:  WIN_FW'(cfg_h)};

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    win_load     = 1'b0;
    frame_done_d = (state_q == ST_ACTIVE) && last_beat;
    cfg_err_d    = cfg_acc && !cfg_ok;
    case (state_q)
      ST_IDLE:   if (pend_full_q && run) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (last_beat) begin
          win_load = 1'b1;
          state_d  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (last_beat) begin
          win_load = pend_full_q;
          if (!run) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Accept is only possible with pending empty, so it never collides with a load.
    if (win_load) begin
      win_d       = pend_q;
      pend_full_d = 1'b0;
    end
    if (cfg_acc && cfg_ok) begin
      pend_d      = cfg_win;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      win_q        <= '{x1: '0, y1: '0, w: WIN_FW'(IN_COLS), h: WIN_FW'(IN_ROWS)};
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  logic [WIN_FW-1:0] x_ext, y_ext;
  logic [WIN_FW:0]   x_lim, y_lim;

  assign x_ext = WIN_FW'(pos_x);
  assign y_ext = WIN_FW'(pos_y);
  assign x_lim = {1'b0, win_q.x1} + {1'b0, win_q.w};
  assign y_lim = {1'b0, win_q.y1} + {1'b0, win_q.h};

  assign crop_en    = (state_q == ST_ACTIVE);
  assign busy       = (state_q != ST_IDLE);
  assign cfg_ready  = !pend_full_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
  assign win_x1     = win_q.x1[CW-1:0];
  assign win_w      = win_q.w[CW-1:0];
  assign win_y1     = win_q.y1[RW-1:0];
  assign win_h      = win_q.h[RW-1:0];
  assign in_window  = crop_en
                   && (y_ext >= win_q.y1) && ({1'b0, y_ext} < y_lim)
                   && (x_ext >= win_q.x1) && ({1'b0, x_ext} < x_lim);

endmodule

// File: tb/tb_crop_ctrl.sv
// Self-checking bench for crop_ctrl against a frame-level reference model.
module tb_crop_ctrl;

  localparam int ROWS = 40;
  localparam int COLS = 40;
  localparam int FR   = ROWS * COLS;
  localparam int CW   = $clog2(COLS + 1);
  localparam int RW   = $clog2(ROWS + 1);
  localparam int VW   = 1 + 2 * CW + 2 * RW + 5;

  localparam int P_IDLE = 0, P_ARM = 1, P_CROP = 2, P_DRAIN = 3;

  logic          clk = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0, cfg_valid = 1'b0, run = 1'b0;
  logic [CW-1:0] cfg_x1 = '0, cfg_w = '0;
  logic [RW-1:0] cfg_y1 = '0, cfg_h = '0;
  logic          cfg_ready, crop_en, in_window, frame_done, cfg_err, busy;
  logic [CW-1:0] win_x1, win_w;
  logic [RW-1:0] win_y1, win_h;
  logic [VW-1:0] dut_vec;

  crop_ctrl #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(ROWS), .IN_COLS(COLS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_x1(cfg_x1), .cfg_w(cfg_w),
    .cfg_y1(cfg_y1), .cfg_h(cfg_h), .run(run), .win_x1(win_x1), .win_w(win_w),
    .win_y1(win_y1), .win_h(win_h), .crop_en(crop_en), .in_window(in_window),
    .frame_done(frame_done), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign dut_vec = {cfg_ready, win_x1, win_y1, win_w, win_h,
                    crop_en, in_window, frame_done, cfg_err, busy};

  int n_cmp = 0, n_fail = 0;

  // Reference model: beat index within the frame, phase, pending and active windows.
  int m_n, m_phase;
  bit m_pf, m_done, m_err;
  int m_px1, m_py1, m_pw, m_ph;
  int m_wx1, m_wy1, m_ww, m_wh;

  function automatic void model_reset();
    m_n = 0; m_phase = P_IDLE; m_pf = 0; m_done = 0; m_err = 0;
    m_px1 = 0; m_py1 = 0; m_pw = 0; m_ph = 0;
    m_wx1 = 0; m_wy1 = 0; m_ww = COLS; m_wh = ROWS;
  endfunction

  function automatic void model_update();
    bit beat, last, acc, ok, load;
    int nph;
    beat = in_valid && out_ready;
    last = beat && (m_n == FR - 1);
    acc  = cfg_valid && !m_pf;
    ok   = (int'(cfg_w) >= 1) && (int'(cfg_h) >= 1) &&
           (int'(cfg_x1) + int'(cfg_w) <= COLS) && (int'(cfg_y1) + int'(cfg_h) <= ROWS);
    m_err  = acc && !ok;
    m_done = (m_phase == P_CROP) && last;
    nph  = m_phase;
    load = 0;
    case (m_phase)
      P_IDLE:  if (m_pf && run) nph = P_ARM;
      P_ARM:   if (!run) nph = P_IDLE; else if (last) begin load = 1; nph = P_CROP; end
      P_CROP:  if (last) begin load = m_pf; if (!run) nph = P_DRAIN; end
      default: nph = P_IDLE;
    endcase
    if (load) begin
      m_wx1 = m_px1; m_wy1 = m_py1; m_ww = m_pw; m_wh = m_ph; m_pf = 0;
    end
    if (acc && ok) begin
      m_px1 = int'(cfg_x1); m_py1 = int'(cfg_y1); m_pw = int'(cfg_w); m_ph = int'(cfg_h);
      m_pf = 1;
    end
    if (beat) m_n = (m_n + 1) % FR;
    m_phase = nph;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    int x, y;
    bit inw;
    x = m_n % COLS;
    y = m_n / COLS;
    inw = (m_phase == P_CROP) && (y >= m_wy1) && (y < m_wy1 + m_wh) &&
          (x >= m_wx1) && (x < m_wx1 + m_ww);
    return {~m_pf, CW'(m_wx1), RW'(m_wy1), CW'(m_ww), RW'(m_wh),
            m_phase == P_CROP, inw, m_done, m_err, m_phase != P_IDLE};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_update();
    #1;
  endtask

  task automatic set_cfg(input int x1, input int y1, input int w, input int h);
    cfg_x1 = CW'(x1); cfg_y1 = RW'(y1); cfg_w = CW'(w); cfg_h = RW'(h);
    cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    @(negedge clk);
    reset = 1'b0;
    tick();
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    int beats = 0, rise_at = -1, done_at = -1, win_cnt = 0;
    bit pre_inw;
    set_cfg(10, 10, 20, 20);
    tick();
    cfg_valid = 1'b0;
    run = 1'b1;
    tick();
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL basic_armed got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      pre_inw = in_window;
      tick();
      beats++;
      if (crop_en === 1'b1 && rise_at < 0) rise_at = beats;
      if (frame_done === 1'b1 && done_at < 0) done_at = beats;
      if (beats > FR && pre_inw) win_cnt++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL basic_cycle beat=%0d got=%h exp=%h", beats, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    in_valid = 1'b0;
    if (rise_at != FR) begin
      n_fail++; $display("FAIL basic_crop_en_rise got=%0d exp=%0d", rise_at, FR);
    end
    n_cmp++;
    if (win_cnt != 400) begin
      n_fail++; $display("FAIL basic_window_beats got=%0d exp=400", win_cnt);
    end
    n_cmp++;
    if (done_at != 2 * FR) begin
      n_fail++; $display("FAIL basic_frame_done got=%0d exp=%0d", done_at, 2 * FR);
    end
    n_cmp++;
  endtask

  task automatic test_bad_cfg();
    set_cfg(30, 0, 11, 5);
    tick();
    cfg_valid = 1'b0;
    if (dut_vec !== exp_vec() || cfg_err !== 1'b1 || cfg_ready !== 1'b1 || win_x1 !== CW'(10)) begin
      n_fail++; $display("FAIL bad_cfg_x got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    set_cfg(0, 0, 5, 0);
    tick();
    cfg_valid = 1'b0;
    if (dut_vec !== exp_vec() || cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_cfg_h0 got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    tick();
    if (dut_vec !== exp_vec() || cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL bad_cfg_pulse got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_midframe_update();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int g = 0; g < FR && m_n != 800; g++) tick();
    set_cfg(30, 35, 10, 5);
    tick();
    cfg_valid = 1'b0;
    if (dut_vec !== exp_vec() || cfg_ready !== 1'b0 || win_x1 !== CW'(10)) begin
      n_fail++; $display("FAIL mid_pending got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    for (int g = 0; g < FR && m_n != 0; g++) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL mid_cycle n=%0d got=%h exp=%h", m_n, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    if (win_x1 !== CW'(30) || win_y1 !== RW'(35) || win_w !== CW'(10) || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_swap got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_drain();
    for (int g = 0; g < FR && m_n != 100; g++) tick();
    run = 1'b0;
    for (int g = 0; g < FR && m_n != 0; g++) begin
      tick();
      if (dut_vec !== exp_vec() || (m_n != 0 && crop_en !== 1'b1)) begin
        n_fail++; $display("FAIL drain_cycle n=%0d got=%h exp=%h", m_n, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    in_valid = 1'b0;
    if (busy !== 1'b1 || crop_en !== 1'b0 || frame_done !== 1'b1) begin
      n_fail++; $display("FAIL drain_state got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    tick();
    if (dut_vec !== exp_vec() || busy !== 1'b0) begin
      n_fail++; $display("FAIL drain_idle got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_armed_run_drop();
    set_cfg(10, 10, 20, 20);
    tick();
    cfg_valid = 1'b0;
    run = 1'b1;
    tick();
    if (dut_vec !== exp_vec() || busy !== 1'b1 || crop_en !== 1'b0) begin
      n_fail++; $display("FAIL armed_enter got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    run = 1'b0;
    tick();
    if (dut_vec !== exp_vec() || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL armed_drop got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    run = 1'b1;
    repeat (5) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL armed_wait got=%h exp=%h", dut_vec, exp_vec());
      end
      n_cmp++;
    end
  endtask

  task automatic test_random_stalls();
    int fcnt = 0, dones = 0;
    bit pre_inw, pre_beat;
    for (int c = 0; c < 40000 && dones < 3; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      pre_inw   = in_window;
      pre_beat  = in_valid && out_ready;
      tick();
      if (pre_inw && pre_beat) fcnt++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rand_cycle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
      end
      n_cmp++;
      if (frame_done === 1'b1) begin
        if (fcnt != 400) begin
          n_fail++; $display("FAIL rand_frame_beats got=%0d exp=400", fcnt);
        end
        n_cmp++;
        dones++;
        fcnt = 0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (dones != 3) begin
      n_fail++; $display("FAIL rand_timeout got=%0d exp=3", dones);
    end
    n_cmp++;
  endtask

  task automatic test_reset_midframe();
    set_cfg(0, 0, 40, 40);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int g = 0; g < FR && m_n != 500; g++) tick();
    if (crop_en !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    #2 reset = 1'b1;
    #1 model_reset();
    if (dut_vec !== exp_vec() || cfg_ready !== 1'b1 || win_w !== CW'(COLS)) begin
      n_fail++; $display("FAIL rst_async got=%h exp=%h", dut_vec, exp_vec());
    end
    n_cmp++;
    tick();
    @(negedge clk);
    reset = 1'b0;
    repeat (45) begin
      tick();
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rst_after n=%0d got=%h exp=%h", m_n, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_bad_cfg();
    test_midframe_update();
    test_drain();
    test_armed_run_drop();
    test_random_stalls();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
